// File: rtl/coherence_bus_ctrl.sv
// Dual-core MSI coherence/memory controller: arbitrates I- and D-cache traffic onto one RAM port.
// Optional macro BUS_RR_ARB_EN selects round-robin arbitration; otherwise core 0 has fixed priority.
`timescale 1ns/1ps
module coherence_bus_ctrl #(
  parameter int CPUS  = 2,
  parameter int WORDS = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] iaddr,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       ccwrite,
  input  logic [1:0]       cctrans,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic [1:0]       iwait,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] iload,
  output logic [1:0][31:0] dload,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr
);

  localparam int            CW         = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD  = CW'(WORDS - 1);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_LOAD, S_FWD, S_WB, S_INV
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   snp_addr_q, snp_addr_d;
  logic          snp_inv_q, snp_inv_d;

  logic [1:0] dreq;
  logic       d_sel, i_sel, oth, access;

  if (CPUS != 2) begin : g_cpus_check
    $error("coherence_bus_ctrl supports CPUS == 2 only");
  end

  assign dreq   = dREN | dWEN | cctrans;
  assign oth    = ~req_q;
  assign access = (ramstate == RAM_ACCESS);

`ifdef BUS_RR_ARB_EN
  logic d_ptr_q, d_ptr_d, i_ptr_q, i_ptr_d;

  assign d_sel = (&dreq) ? d_ptr_q : ~dreq[0];
  assign i_sel = (&iREN) ? i_ptr_q : ~iREN[0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      d_ptr_q <= 1'b0;
      i_ptr_q <= 1'b0;
    end else begin
      d_ptr_q <= d_ptr_d;
      i_ptr_q <= i_ptr_d;
    end
  end

  // The I pointer only moves once a fetch actually completes, so a stalled core keeps its grant.
  always_comb begin
    d_ptr_d = d_ptr_q;
    i_ptr_d = i_ptr_q;
    if (state_q == S_IDLE) begin
      if (|dreq)                 d_ptr_d = ~d_sel;
      else if ((|iREN) && access) i_ptr_d = ~i_sel;
    end
  end
`else
  assign d_sel = ~dreq[0];
  assign i_sel = ~iREN[0];
`endif

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      cnt_q      <= '0;
      snp_addr_q <= '0;
      snp_inv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      snp_addr_q <= snp_addr_d;
      snp_inv_q  <= snp_inv_d;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    snp_addr_d = snp_addr_q;
    snp_inv_d  = snp_inv_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|dreq) begin
          req_d = d_sel;
          if (dWEN[d_sel])      state_d = S_WB;
          else if (dREN[d_sel]) state_d = S_SNOOP;
          else                  state_d = S_INV;
        end
      end
      S_SNOOP: begin
        cnt_d      = '0;
        snp_addr_d = daddr[req_q];
        snp_inv_d  = ccwrite[req_q];
        state_d    = cctrans[oth] ? S_FWD : S_LOAD;
      end
      S_LOAD, S_FWD, S_WB: begin
        if (access) begin
          if (cnt_q == LAST_WORD) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_INV:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are gated by nRST so the reset values appear in the same cycle reset is asserted.
  always_comb begin
    iwait       = 2'b11;
    dwait       = 2'b11;
    iload       = '0;
    dload       = '0;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    if (nRST) begin
      unique case (state_q)
        S_IDLE: begin
          if (!(|dreq) && (|iREN)) begin
            ramaddr = iaddr[i_sel];
            ramREN  = 1'b1;
            if (access) begin
              iload[i_sel] = ramload;
              iwait[i_sel] = 1'b0;
            end
          end
        end
        S_SNOOP: begin
          ccwait[oth]      = 1'b1;
          ccsnoopaddr[oth] = daddr[req_q];
          ccinv[oth]       = ccwrite[req_q];
        end
        S_LOAD: begin
          ccwait[oth]      = 1'b1;
          ccsnoopaddr[oth] = snp_addr_q;
          ccinv[oth]       = snp_inv_q;
          ramREN           = 1'b1;
          ramaddr          = daddr[req_q];
          dload[req_q]     = ramload;
          if (access) dwait[req_q] = 1'b0;
        end
        S_FWD: begin
          ccwait[oth]      = 1'b1;
          ccsnoopaddr[oth] = snp_addr_q;
          ccinv[oth]       = snp_inv_q;
          ramWEN           = 1'b1;
          ramaddr          = daddr[oth];
          ramstore         = dstore[oth];
          dload[req_q]     = dstore[oth];
          if (access) begin
            dwait[oth]   = 1'b0;
            dwait[req_q] = 1'b0;
          end
        end
        S_WB: begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[req_q];
          ramstore = dstore[req_q];
          if (access) dwait[req_q] = 1'b0;
        end
        S_INV: begin
          ccwait[oth]      = 1'b1;
          ccinv[oth]       = 1'b1;
          ccsnoopaddr[oth] = daddr[req_q];
          dwait[req_q]     = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: directed table, multi-cycle sequences, random transactions.
`timescale 1ns/1ps
module tb_coherence_bus_ctrl;

  localparam int         WORDS    = 2;
  localparam logic [1:0] R_FREE   = 2'd0;
  localparam logic [1:0] R_BUSY   = 2'd1;
  localparam logic [1:0] R_ACCESS = 2'd2;
  localparam logic [1:0] R_ERROR  = 2'd3;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [31:0]      ramload;
  logic [1:0]       ramstate;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic [31:0]      ramaddr, ramstore;
  logic             ramREN, ramWEN;

  int n_checks = 0;
  int n_fail   = 0;

  coherence_bus_ctrl #(.CPUS(2), .WORDS(WORDS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .ramload(ramload), .ramstate(ramstate),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]  iren;
    logic [31:0] ia0, ia1, rl;
    logic [1:0]  rs;
    logic [1:0]  e_iwait;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [63:0] e_iload;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic clr_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = R_FREE;
  endtask

  task automatic apply_reset();
    clr_inputs();
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // One cache-side transaction: 0 I-fetch, 1 D read miss, 2 write-back, 3 upgrade.
  task automatic run_txn(input int kind, input logic r);
    logic        o, dirty, ccw, snooped, done;
    logic [31:0] base, ia, addr;
    logic [31:0] wdata[WORDS];
    logic [31:0] fdata[WORDS];
    beat_t       exp_q[$];
    logic [31:0] rx_q[$];
    beat_t       b;
    int          kr, ko, got, need, sel;

    o     = ~r;
    base  = $urandom & 32'hFFFF_FFF0;
    ia    = $urandom & 32'hFFFF_FFFC;
    dirty = ($urandom_range(0, 1) != 0);
    ccw   = ($urandom_range(0, 1) != 0);
    for (int k = 0; k < WORDS; k++) begin
      wdata[k] = $urandom;
      fdata[k] = $urandom;
    end

    need = 1;
    case (kind)
      0: begin
        exp_q.push_back('{1'b0, ia, mem_f(ia)});
        rx_q.push_back(mem_f(ia));
      end
      1: begin
        need = WORDS;
        for (int k = 0; k < WORDS; k++) begin
          addr = base + 32'(4 * k);
          if (dirty) begin
            exp_q.push_back('{1'b1, addr, fdata[k]});
            rx_q.push_back(fdata[k]);
          end else begin
            exp_q.push_back('{1'b0, addr, mem_f(addr)});
            rx_q.push_back(mem_f(addr));
          end
        end
      end
      2: begin
        need = WORDS;
        for (int k = 0; k < WORDS; k++)
          exp_q.push_back('{1'b1, base + 32'(4 * k), wdata[k]});
      end
      default: need = 1;
    endcase

    kr = 0; ko = 0; got = 0; snooped = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
      case (kind)
        0: begin iREN[r] = 1'b1; iaddr[r] = ia; end
        1: begin dREN[r] = 1'b1; ccwrite[r] = ccw; end
        2: dWEN[r] = 1'b1;
        default: cctrans[r] = 1'b1;
      endcase
      daddr[r]  = base + 32'(4 * kr);
      dstore[r] = wdata[(kr < WORDS) ? kr : WORDS - 1];
      daddr[o]  = base + 32'(4 * ko);
      dstore[o] = fdata[(ko < WORDS) ? ko : WORDS - 1];
      if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 2);
        ramstate = (sel == 0) ? R_FREE : (sel == 1) ? R_BUSY : R_ERROR;
      end else begin
        ramstate = R_ACCESS;
      end
      #1;
      if (ccwait[o] && !snooped) begin
        snooped = 1'b1;
        check("rnd_snoop_addr", ccsnoopaddr[o], base);
        check("rnd_snoop_inv", ccinv[o], (kind == 3) ? 1'b1 : ccw);
        if (kind == 1) begin
          cctrans[o] = dirty;
          #1;
        end
      end
      ramload = mem_f(ramaddr);
      #1;
      check("rnd_ren_wen_excl", ramREN & ramWEN, 1'b0);
      if (ramstate == R_ACCESS && (ramREN || ramWEN)) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_beat", {ramREN, ramWEN}, 2'b00);
        end else begin
          b = exp_q.pop_front();
          check("rnd_beat_we", ramWEN, b.we);
          check("rnd_beat_addr", ramaddr, b.addr);
          check("rnd_beat_data", ramWEN ? ramstore : ramload, b.data);
        end
      end
      if (kind == 0 && !iwait[r]) begin
        check("rnd_iload", iload[r], rx_q.pop_front());
        got++;
      end
      if (kind != 0 && !dwait[r]) begin
        if (kind == 1) begin
          check("rnd_dload", dload[r], rx_q.pop_front());
          if (dirty) check("rnd_fwd_owner_dwait", dwait[o], 1'b0);
        end
        got++;
        kr++;
      end
      if (!dwait[o]) ko++;
      if (got == need) done = 1'b1;
      tick();
    end
    check("rnd_txn_complete", got, need);
    check("rnd_beats_left", exp_q.size(), 0);
    check("rnd_snoop_seen", snooped, (kind == 1 || kind == 3));
    clr_inputs();
    #1;
    check("rnd_idle_after", {ramREN, ramWEN, ccwait}, 4'b0000);
    tick();
  endtask

  initial begin
    vecs[0] = '{2'b01, 32'h40,  32'h0,   32'hDEAD_BEEF, R_BUSY,   2'b11, 1'b1, 32'h40,  64'h0};
    vecs[1] = '{2'b01, 32'h40,  32'h0,   32'hDEAD_BEEF, R_BUSY,   2'b11, 1'b1, 32'h40,  64'h0};
    vecs[2] = '{2'b01, 32'h40,  32'h0,   32'hDEAD_BEEF, R_ACCESS, 2'b10, 1'b1, 32'h40,  {32'h0, 32'hDEAD_BEEF}};
    vecs[3] = '{2'b10, 32'h0,   32'h80,  32'h1111,      R_ACCESS, 2'b01, 1'b1, 32'h80,  {32'h1111, 32'h0}};
    vecs[4] = '{2'b10, 32'h0,   32'h80,  32'h1111,      R_FREE,   2'b11, 1'b1, 32'h80,  64'h0};
    vecs[5] = '{2'b01, 32'h44,  32'h0,   32'h1111,      R_ERROR,  2'b11, 1'b1, 32'h44,  64'h0};
    vecs[6] = '{2'b00, 32'h44,  32'h88,  32'h1111,      R_ACCESS, 2'b11, 1'b0, 32'h0,   64'h0};
    vecs[7] = '{2'b11, 32'h100, 32'h200, 32'h2222,      R_ACCESS, 2'b10, 1'b1, 32'h100, {32'h0, 32'h2222}};
`ifdef BUS_RR_ARB_EN
    vecs[8] = '{2'b11, 32'h100, 32'h200, 32'h3333,      R_ACCESS, 2'b01, 1'b1, 32'h200, {32'h3333, 32'h0}};
`else
    vecs[8] = '{2'b11, 32'h100, 32'h200, 32'h3333,      R_ACCESS, 2'b10, 1'b1, 32'h100, {32'h0, 32'h3333}};
`endif

    // Reset state, with an I request present that must not leak through
    clr_inputs();
    nRST = 1'b0;
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = R_ACCESS;
    #2;
    check("rst_iwait", iwait, 2'b11);
    check("rst_dwait", dwait, 2'b11);
    check("rst_ren_wen", {ramREN, ramWEN}, 2'b00);
    check("rst_ccwait", ccwait, 2'b00);
    check("rst_ramaddr", ramaddr, 32'h0);
    @(negedge CLK);
    clr_inputs();
    nRST = 1'b1;

    // Instruction fetch table
    for (int i = 0; i < 9; i++) begin
      iREN = vecs[i].iren; iaddr[0] = vecs[i].ia0; iaddr[1] = vecs[i].ia1;
      ramload = vecs[i].rl; ramstate = vecs[i].rs;
      #1;
      check($sformatf("ifetch_v%0d_iwait", i), iwait, vecs[i].e_iwait);
      check($sformatf("ifetch_v%0d_ramren", i), ramREN, vecs[i].e_ren);
      check($sformatf("ifetch_v%0d_ramaddr", i), ramaddr, vecs[i].e_addr);
      check($sformatf("ifetch_v%0d_iload", i), iload, vecs[i].e_iload);
      tick();
    end

    // Clean read miss by core 1
    apply_reset();
    dREN[1] = 1'b1; daddr[1] = 32'h500; #1;
    check("clean_idle_dwait", dwait, 2'b11);
    tick(); #1;
    check("clean_snoop_ccwait", ccwait, 2'b01);
    check("clean_snoop_addr", ccsnoopaddr, {32'h0, 32'h500});
    check("clean_snoop_inv", ccinv, 2'b00);
    check("clean_snoop_ren", ramREN, 1'b0);
    tick(); ramstate = R_BUSY; #1;
    check("clean_busy_ren", ramREN, 1'b1);
    check("clean_busy_addr", ramaddr, 32'h500);
    check("clean_busy_dwait", dwait, 2'b11);
    tick(); ramstate = R_ACCESS; ramload = 32'hA0; #1;
    check("clean_w0_dwait", dwait, 2'b01);
    check("clean_w0_dload", dload, {32'hA0, 32'h0});
    tick(); daddr[1] = 32'h504; ramload = 32'hA1; #1;
    check("clean_w1_addr", ramaddr, 32'h504);
    check("clean_w1_dwait", dwait, 2'b01);
    check("clean_w1_dload", dload, {32'hA1, 32'h0});
    check("clean_w1_ccwait", ccwait, 2'b01);
    tick(); clr_inputs(); #1;
    check("clean_done", {ramREN, dwait, ccwait}, 5'b01100);

    // Read miss with dirty remote copy: cache-to-cache forward
    dREN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h600;
    tick();
    cctrans[1] = 1'b1; daddr[1] = 32'h600; dstore[1] = 32'h1234; #1;
    check("fwd_snoop_ccwait", ccwait, 2'b10);
    check("fwd_snoop_inv", ccinv, 2'b10);
    check("fwd_snoop_addr", ccsnoopaddr, {32'h600, 32'h0});
    tick(); cctrans[1] = 1'b0; ramstate = R_BUSY; #1;
    check("fwd_busy_en", {ramREN, ramWEN}, 2'b01);
    check("fwd_busy_addr", ramaddr, 32'h600);
    check("fwd_busy_store", ramstore, 32'h1234);
    check("fwd_busy_dload", dload, {32'h0, 32'h1234});
    check("fwd_busy_dwait", dwait, 2'b11);
    check("fwd_busy_inv", ccinv, 2'b10);
    tick(); ramstate = R_ACCESS; #1;
    check("fwd_w0_dwait", dwait, 2'b00);
    tick(); daddr[1] = 32'h604; dstore[1] = 32'h5678; #1;
    check("fwd_w1_addr", ramaddr, 32'h604);
    check("fwd_w1_store", ramstore, 32'h5678);
    check("fwd_w1_dload", dload, {32'h0, 32'h5678});
    check("fwd_w1_dwait", dwait, 2'b00);
    tick(); clr_inputs(); #1;
    check("fwd_done", {ramWEN, ccinv}, 3'b000);

    // Simultaneous write-backs
    apply_reset();
    dWEN = 2'b11; daddr[0] = 32'h700; daddr[1] = 32'h800;
    dstore[0] = 32'h70; dstore[1] = 32'h80; ramstate = R_ACCESS; #1;
    check("wb2_idle_wen", ramWEN, 1'b0);
    tick(); #1;
    check("wb2_first_addr", ramaddr, 32'h700);
    check("wb2_first_store", ramstore, 32'h70);
    check("wb2_first_dwait", dwait, 2'b10);
    tick(); daddr[0] = 32'h704; dstore[0] = 32'h71; #1;
    check("wb2_first_w1_addr", ramaddr, 32'h704);
    check("wb2_first_w1_store", ramstore, 32'h71);
    tick(); daddr[0] = 32'h740; dstore[0] = 32'h74; #1;
    check("wb2_rearb_wen", ramWEN, 1'b0);
    tick(); #1;
`ifdef BUS_RR_ARB_EN
    check("wb2_second_addr", ramaddr, 32'h800);
    check("wb2_second_dwait", dwait, 2'b01);
`else
    check("wb2_second_addr", ramaddr, 32'h740);
    check("wb2_second_dwait", dwait, 2'b10);
`endif
    tick(); #1;
    check("wb2_second_w1_wen", ramWEN, 1'b1);
    tick(); clr_inputs(); #1;
    check("wb2_done_wen", ramWEN, 1'b0);

    // Upgrade: cctrans alone gives a single invalidate cycle
    tick();
    cctrans[0] = 1'b1; daddr[0] = 32'h900; #1;
    check("inv_idle_ccwait", ccwait, 2'b00);
    tick(); #1;
    check("inv_ccwait", ccwait, 2'b10);
    check("inv_ccinv", ccinv, 2'b10);
    check("inv_addr", ccsnoopaddr, {32'h900, 32'h0});
    check("inv_dwait", dwait, 2'b10);
    tick(); clr_inputs(); #1;
    check("inv_done", {ccinv, dwait}, 4'b0011);

    // Asynchronous reset in the middle of a write-back
    apply_reset();
    dWEN[1] = 1'b1; daddr[1] = 32'hA00; dstore[1] = 32'hAA; ramstate = R_BUSY; iREN = 2'b01;
    tick(); #1;
    check("rstwb_wen", ramWEN, 1'b1);
    check("rstwb_addr", ramaddr, 32'hA00);
    check("rstwb_iwait", iwait, 2'b11);
    #2; nRST = 1'b0; #1;
    check("rstwb_en_cleared", {ramREN, ramWEN}, 2'b00);
    check("rstwb_addr_cleared", ramaddr, 32'h0);
    check("rstwb_store_cleared", ramstore, 32'h0);
    check("rstwb_waits", {iwait, dwait}, 4'b1111);
    @(negedge CLK);
    clr_inputs();
    nRST = 1'b1; #1;
    check("rstwb_idle_wen", ramWEN, 1'b0);
    iREN = 2'b01; iaddr[0] = 32'h44; ramstate = R_ACCESS; ramload = 32'h4444; #1;
    check("rstwb_fetch_iwait", iwait, 2'b10);
    check("rstwb_fetch_iload", iload, {32'h0, 32'h4444});
    tick(); clr_inputs();

    // Randomized single-requester transactions against the transaction-level model
    apply_reset();
    for (int t = 0; t < 40; t++)
      run_txn(int'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
